// File: rtl/move_wide_sequencer.sv
// Move-wide (MOVZ/MOVN/MOVK) decoder and sequencer feeding the datapath control word.
// cw[32] is a reserved spare bit held at 0; the listed fields occupy cw[31:0].
//
// state | meaning
// IDLE  | no instruction latched, NOP control word
// EX1   | first execute cycle (MOVZ/MOVN write, MOVK clear, or illegal)
// EX2   | MOVK second cycle, OR the shifted immediate into Rd

module move_wide_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int IMM_WIDTH  = 16,
    parameter int HW_BITS    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           I,
    output logic [32:0]           cw,
    output logic [DATA_WIDTH-1:0] k,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EX1  = 2'd1,
        EX2  = 2'd2
    } state_t;

    localparam logic [8:0] OP_MOVZ = 9'b110100101;
    localparam logic [8:0] OP_MOVN = 9'b100100101;
    localparam logic [8:0] OP_MOVK = 9'b111100101;

    localparam logic [DATA_WIDTH-1:0] FIELD_ONES =
        {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, {IMM_WIDTH{1'b1}}};

    state_t state, state_nx;
    logic [31:0] ir;

    logic [8:0]           opcode;
    logic [HW_BITS-1:0]   hw;
    logic [IMM_WIDTH-1:0] imm;
    logic [4:0]           rd;
    logic [31:0]          shift_amt;
    logic                 is_movz, is_movn, is_movk;
    logic                 shift_ok, legal;
    logic [DATA_WIDTH-1:0] field_mask, field_val;

    logic       alu_en, alu_bs, rf_b_en, rf_w, ram_en, ram_w, pc_is, status_ld;
    logic [4:0] alu_fs, rf_sa, rf_sb, rf_da;
    logic [1:0] pc_fs, next_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                ir <= I;
            end
        end
    end

    assign opcode  = ir[31:23];
    assign hw      = ir[IMM_WIDTH+HW_BITS+4:IMM_WIDTH+5];
    assign imm     = ir[IMM_WIDTH+4:5];
    assign rd      = ir[4:0];
    assign is_movz = (opcode == OP_MOVZ);
    assign is_movn = (opcode == OP_MOVN);
    assign is_movk = (opcode == OP_MOVK);

    // A field that would spill past the datapath is rejected rather than truncated.
    assign shift_amt  = 32'(hw) * 32'(IMM_WIDTH);
    assign shift_ok   = (shift_amt + 32'(IMM_WIDTH)) <= 32'(DATA_WIDTH);
    assign legal      = (is_movz || is_movn || is_movk) && shift_ok;
    assign field_mask = FIELD_ONES << shift_amt;
    assign field_val  = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm} << shift_amt;

    always_comb begin
        state_nx   = state;
        alu_en     = 1'b0;
        alu_bs     = 1'b0;
        alu_fs     = 5'b00000;
        rf_b_en    = 1'b0;
        rf_sa      = 5'd0;
        rf_sb      = 5'd0;
        rf_da      = 5'd0;
        rf_w       = 1'b0;
        ram_en     = 1'b0;
        ram_w      = 1'b0;
        pc_fs      = 2'b00;
        pc_is      = 1'b0;
        status_ld  = 1'b0;
        next_state = 2'b00;
        k          = '0;
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = EX1;
                end
            end

            EX1: begin
                busy   = 1'b1;
                alu_en = 1'b1;
                alu_bs = 1'b1;
                rf_da  = rd;
                if (!legal) begin
                    alu_en   = 1'b0;
                    pc_fs    = 2'b01;
                    illegal  = 1'b1;
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (is_movk) begin
                    // Clear the target field first; PC held until the OR pass.
                    rf_sa      = rd;
                    alu_fs     = 5'b00010;
                    k          = field_mask;
                    rf_w       = 1'b1;
                    next_state = 2'b01;
                    state_nx   = EX2;
                end else begin
                    rf_sa    = 5'd31;
                    alu_fs   = is_movn ? 5'b00110 : 5'b00100;
                    k        = field_val;
                    rf_w     = 1'b1;
                    pc_fs    = 2'b01;
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end

            EX2: begin
                busy     = 1'b1;
                alu_en   = 1'b1;
                alu_bs   = 1'b1;
                rf_da    = rd;
                rf_sa    = rd;
                alu_fs   = 5'b00100;
                k        = field_val;
                rf_w     = 1'b1;
                pc_fs    = 2'b01;
                done     = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign cw = {1'b0, alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da,
                 rf_w, ram_en, ram_w, pc_fs, pc_is, status_ld, next_state};

endmodule

// File: tb/tb_move_wide_sequencer.sv
// Scoreboard bench for move_wide_sequencer: a 64-bit and a 32-bit instance share stimulus,
// each with its own reference model queue and monitor.

module tb_move_wide_sequencer;

    localparam logic [8:0] OP_Z = 9'b110100101;
    localparam logic [8:0] OP_N = 9'b100100101;
    localparam logic [8:0] OP_K = 9'b111100101;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [31:0] I;

    logic [32:0] cw_a, cw_b;
    logic [63:0] k_a;
    logic [31:0] k_b;
    logic        busy_a, done_a, illegal_a;
    logic        busy_b, done_b, illegal_b;

    always #5 clock = ~clock;

    move_wide_sequencer #(.DATA_WIDTH(64), .IMM_WIDTH(16), .HW_BITS(2)) dut_a (
        .clock(clock), .reset(reset), .start(start), .I(I),
        .cw(cw_a), .k(k_a), .busy(busy_a), .done(done_a), .illegal(illegal_a)
    );

    move_wide_sequencer #(.DATA_WIDTH(32), .IMM_WIDTH(16), .HW_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .start(start), .I(I),
        .cw(cw_b), .k(k_b), .busy(busy_b), .done(done_b), .illegal(illegal_b)
    );

    typedef struct {
        logic [32:0] cw;
        logic [32:0] mask;
        logic [63:0] k;
        logic        done;
        logic        illegal;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   left_a = 0, left_b = 0;
    int   compared = 0, mismatched = 0;
    bit   mon_en = 1'b0;

    function automatic logic [32:0] pack_cw(
        input logic alu_en, input logic alu_bs, input logic [4:0] alu_fs, input logic rf_b_en,
        input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da, input logic rf_w,
        input logic ram_en, input logic ram_w, input logic [1:0] pc_fs, input logic pc_is,
        input logic status_ld, input logic [1:0] ns);
        return {1'b0, alu_en, alu_bs, alu_fs, rf_b_en, sa, sb, da, rf_w,
                ram_en, ram_w, pc_fs, pc_is, status_ld, ns};
    endfunction

    // Reference: what a move-wide instruction does, computed with plain arithmetic.
    task automatic model(input logic [31:0] instr, input int dw, output int len,
                         output exp_t e1, output exp_t e2);
        logic [8:0]      op;
        int              sh;
        longint unsigned imm, wmask, v, f;
        logic [4:0]      rd;
        bit              z, n, kk, ok;
        logic [32:0]     ill_mask;
        op    = instr[31:23];
        sh    = int'(instr[22:21]) * 16;
        imm   = longint'(instr[20:5]);
        rd    = instr[4:0];
        wmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
        v     = (imm << sh) & wmask;
        f     = (64'hFFFF << sh) & wmask;
        z     = (op == OP_Z);
        n     = (op == OP_N);
        kk    = (op == OP_K);
        ok    = (z || n || kk) && (sh + 16 <= dw);
        ill_mask = '1;
        ill_mask[29:25] = '0;
        ill_mask[23:19] = '0;
        e2.cw = '0; e2.mask = '1; e2.k = '0; e2.done = 1'b0; e2.illegal = 1'b0;
        if (!ok) begin
            len = 1;
            e1.cw = pack_cw(0, 1, 0, 0, 0, 0, rd, 0, 0, 0, 2'b01, 0, 0, 2'b00);
            e1.mask = ill_mask; e1.k = '0; e1.done = 1'b1; e1.illegal = 1'b1;
        end else if (kk) begin
            len = 2;
            e1.cw = pack_cw(1, 1, 5'b00010, 0, rd, 0, rd, 1, 0, 0, 2'b00, 0, 0, 2'b01);
            e1.mask = '1; e1.k = f; e1.done = 1'b0; e1.illegal = 1'b0;
            e2.cw = pack_cw(1, 1, 5'b00100, 0, rd, 0, rd, 1, 0, 0, 2'b01, 0, 0, 2'b00);
            e2.mask = '1; e2.k = v; e2.done = 1'b1; e2.illegal = 1'b0;
        end else begin
            len = 1;
            e1.cw = pack_cw(1, 1, n ? 5'b00110 : 5'b00100, 0, 5'd31, 0, rd, 1, 0, 0,
                            2'b01, 0, 0, 2'b00);
            e1.mask = '1; e1.k = v; e1.done = 1'b1; e1.illegal = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own busy bookkeeping.
    task automatic cycle(input bit rst, input bit st, input logic [31:0] instr);
        int   len;
        exp_t e1, e2;
        reset = rst;
        start = st;
        I     = instr;
        @(posedge clock);
        if (rst) begin
            left_a = 0; left_b = 0;
            q_a.delete(); q_b.delete();
        end else begin
            if (left_a == 0) begin
                if (st) begin
                    model(instr, 64, len, e1, e2);
                    q_a.push_back(e1);
                    if (len == 2) q_a.push_back(e2);
                    left_a = len;
                end
            end else begin
                left_a--;
            end
            if (left_b == 0) begin
                if (st) begin
                    model(instr, 32, len, e1, e2);
                    q_b.push_back(e1);
                    if (len == 2) q_b.push_back(e2);
                    left_b = len;
                end
            end else begin
                left_b--;
            end
        end
        #1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (busy_a) begin
                if (q_a.size() == 0) begin
                    chk("a_busy_unexpected", 64'(busy_a), 64'd0);
                end else begin
                    ea = q_a.pop_front();
                    chk("a_cw", 64'(cw_a & ea.mask), 64'(ea.cw & ea.mask));
                    chk("a_k", k_a, ea.k);
                    chk("a_done", 64'(done_a), 64'(ea.done));
                    chk("a_illegal", 64'(illegal_a), 64'(ea.illegal));
                end
            end else begin
                chk("a_idle_cw", 64'(cw_a), 64'd0);
                chk("a_idle_k", k_a, 64'd0);
                chk("a_idle_flags", 64'({done_a, illegal_a}), 64'd0);
            end
            if (busy_b) begin
                if (q_b.size() == 0) begin
                    chk("b_busy_unexpected", 64'(busy_b), 64'd0);
                end else begin
                    eb = q_b.pop_front();
                    chk("b_cw", 64'(cw_b & eb.mask), 64'(eb.cw & eb.mask));
                    chk("b_k", 64'(k_b), eb.k);
                    chk("b_done", 64'(done_b), 64'(eb.done));
                    chk("b_illegal", 64'(illegal_b), 64'(eb.illegal));
                end
            end else begin
                chk("b_idle_cw", 64'(cw_b), 64'd0);
                chk("b_idle_k", 64'(k_b), 64'd0);
                chk("b_idle_flags", 64'({done_b, illegal_b}), 64'd0);
            end
        end
    end

    initial begin
        logic [31:0] movz_beef, movn_one, movk_1234, movk_hw2, bad_op, ins, rnd;
        logic [8:0]  op;
        movz_beef = {OP_Z, 2'd2, 16'hBEEF, 5'd3};
        movn_one  = {OP_N, 2'd0, 16'h0001, 5'd7};
        movk_1234 = {OP_K, 2'd1, 16'h1234, 5'd5};
        movk_hw2  = {OP_K, 2'd2, 16'hCAFE, 5'd9};
        bad_op    = {9'h1FF, 2'd0, 16'h5555, 5'd1};

        reset = 1'b1; start = 1'b0; I = '0;
        @(posedge clock);
        #1 mon_en = 1'b1;
        cycle(1, 0, 0);
        cycle(0, 0, 0);

        cycle(0, 1, movz_beef);
        cycle(0, 0, 0);
        cycle(0, 1, movn_one);
        cycle(0, 0, 0);
        cycle(0, 1, movk_1234);
        cycle(0, 1, movz_beef);
        cycle(0, 1, movn_one);
        cycle(0, 1, movn_one);
        cycle(0, 0, 0);
        cycle(0, 1, bad_op);
        cycle(0, 0, 0);
        cycle(0, 1, movk_hw2);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, {OP_Z, 2'd3, 16'hFFFF, 5'd31});
        cycle(0, 0, 0);
        cycle(0, 1, movk_1234);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 1, movz_beef);
        cycle(0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: op = OP_Z;
                1: op = OP_N;
                2: op = OP_K;
                default: op = 9'($urandom());
            endcase
            rnd = $urandom();
            ins = {op, rnd[22:0]};
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 6), ins);
        end

        repeat (5) cycle(0, 0, 0);
        chk("a_leftover", 64'(q_a.size()), 64'd0);
        chk("b_leftover", 64'(q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/move_wide_sequencer.md
Name: move_wide_sequencer

Overview:
- Parametrised successor to the single-cycle MOVZ instruction-word decoder in the control unit.
- Decodes the whole move-wide family (MOVZ, MOVN, MOVK) and emits one 33-bit control word per execute cycle, plus the K constant.
- MOVZ and MOVN complete in one cycle; MOVK is sequenced over two cycles: clear the field, then OR it in.
- Sits between the control unit's fetch/dispatch FSM and the datapath (ALU, register file, PC).

Parameters:
- DATA_WIDTH, 64: datapath and K width.
- IMM_WIDTH, 16: immediate field width, I[IMM_WIDTH+4:5].
- HW_BITS, 2: width of the hw shift field, I[IMM_WIDTH+HW_BITS+4:IMM_WIDTH+5]. Shift amount = hw*IMM_WIDTH.
- Legal configuration: IMM_WIDTH+HW_BITS+5 <= 23.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  dispatch strobe; I is valid this cycle.
- I  in  32  instruction word; opcode is I[31:23].
- cw  out  33  control word, fields MSB to LSB:
  - alu_en, alu_bs, alu_fs[4:0], rf_b_en
  - rf_sa[4:0], rf_sb[4:0], rf_da[4:0], rf_w
  - ram_en, ram_w, pc_fs[1:0], pc_is, status_ld, next_state[1:0]
- k  out  DATA_WIDTH  ALU B constant.
- busy  out  1  high while an instruction is latched.
- done  out  1  high on the final execute cycle.
- illegal  out  1  one-cycle flag for an unsupported opcode or shift.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state=IDLE; cw, k, busy, done and illegal all 0. A reset mid-MOVK aborts the instruction; no further rf_w is issued.
- States: IDLE, EX1, EX2.
- Latch: on start in IDLE, capture I into ir. Start while busy is ignored.
- Opcodes:
  - 110100101 = MOVZ
  - 100100101 = MOVN
  - 111100101 = MOVK
  - anything else is illegal.
- Shift field: F = {IMM_WIDTH ones} << (hw*IMM_WIDTH). V = imm << (hw*IMM_WIDTH). Both are zero-filled, never one-filled. If hw*IMM_WIDTH+IMM_WIDTH > DATA_WIDTH, the instruction is illegal.
- Transitions:
  - IDLE + start -> EX1 (registered; outputs for EX1 are valid the cycle after start).
  - EX1 -> EX2 if MOVK and legal.
  - EX1 -> IDLE otherwise.
  - EX2 -> IDLE.
- IDLE outputs: cw = all zero (NOP: no write, pc_fs=00). busy=0, done=0.
- Common fields in EX1/EX2: alu_en=1, alu_bs=1, rf_b_en=0, rf_sb=0, rf_da=Rd (I[4:0]), ram_en=0, ram_w=0, pc_is=0, status_ld=0. busy=1.
- MOVZ in EX1: rf_sa=31, alu_fs=001_00 (A|B), k=V, rf_w=1, pc_fs=01, next_state=00, done=1.
- MOVN in EX1: rf_sa=31, alu_fs=001_10 (A|~B), k=V, rf_w=1, pc_fs=01, next_state=00, done=1.
- MOVK in EX1: rf_sa=Rd, alu_fs=000_10 (A&~B), k=F, rf_w=1, pc_fs=00 (PC held), next_state=01, done=0.
- MOVK in EX2: rf_sa=Rd, alu_fs=001_00, k=V, rf_w=1, pc_fs=01, next_state=00, done=1.
- Illegal in EX1: cw has rf_w=0 and alu_en=0, pc_fs=01, next_state=00. illegal=1, done=1, k=0.
- PC advances exactly once per instruction, always on the done cycle.
- Rd=31 is written as commanded; the register file discards writes to XZR.
- start on the same cycle as done is ignored. The dispatcher must wait for busy=0.

Test Plan:
- MOVZ X3, #0xBEEF, LSL 32: start, then 1 cycle -> k=0x0000_BEEF_0000_0000, alu_fs=00100, rf_sa=31, rf_da=3, rf_w=1, pc_fs=01, done=1. Next cycle: busy=0, cw=0.
- MOVN X7, #0x0001, LSL 0 -> k=0x1, alu_fs=00110, done in EX1. Datapath result 0xFFFF_FFFF_FFFF_FFFE.
- MOVK X5, #0x1234, LSL 16 with X5=0xAAAA_AAAA_AAAA_AAAA:
  - EX1: k=0x0000_0000_FFFF_0000, alu_fs=00010, pc_fs=00, next_state=01.
  - EX2: k=0x0000_0000_1234_0000, alu_fs=00100, pc_fs=01.
  - Final X5=0xAAAA_AAAA_1234_AAAA; busy high exactly 2 cycles.
- Illegal opcode 0x1FF, or DATA_WIDTH=32 with hw=2 -> illegal=1 and done=1 for one cycle, rf_w=0, pc_fs=01.
- reset asserted during MOVK EX1 -> next cycle state IDLE, all outputs 0, no EX2 write.
- start pulsed during EX1 and on the EX2/done cycle -> ignored; a new start after busy=0 is accepted normally.
